// File: rtl/connect_pkg.sv
// rtl/connect_pkg.sv - shared cell codes, line directions and board indexing helpers
package connect_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_P1    = 2'b01;
    localparam cell_t CELL_P2    = 2'b10;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_DR    = 2'd2;
    localparam logic [1:0] DIR_DL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    function automatic int dir_dr(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int dir_dc(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 1;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/win_window_check.sv
// rtl/win_window_check.sv - combinational test of one WIN_LEN cell window against a target player
module win_window_check
    import connect_pkg::*;
#(
    parameter int WIN_LEN = 5
) (
    input  logic [2*WIN_LEN-1:0] cells,
    input  logic                 valid,
    input  cell_t                target,
    output logic                 match
);

    always_comb begin
        match = valid && ((target == CELL_P1) || (target == CELL_P2));
        for (int k = 0; k < WIN_LEN; k++) begin
            if (cells[2*k +: 2] != target) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/win_scanner.sv
// rtl/win_scanner.sv - sequential board scanner: one anchor cell per clock, four line directions
module win_scanner
    import connect_pkg::*;
#(
    parameter int ROWS    = 7,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 5
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [2*ROWS*COLS-1:0]    grid,
    input  logic [1:0]                player,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                winner,
    output logic                      draw,
    output logic [$clog2(ROWS)-1:0]   win_row,
    output logic [$clog2(COLS)-1:0]   win_col,
    output logic [1:0]                win_dir
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    scan_state_t state, state_next;

    logic [2*ROWS*COLS-1:0] grid_q;
    cell_t                  player_q;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic                   empty_seen;

    logic [2*WIN_LEN-1:0]   win_cells [4];
    logic [3:0]             win_valid;
    logic [3:0]             dir_match;
    cell_t                  anchor;
    cell_t                  target;
    logic                   hit;
    logic [1:0]             hit_dir;
    logic                   last_anchor;

    assign anchor      = grid_q[2*cell_idx(int'(row_q), int'(col_q), COLS) +: 2];
    // Either-player mode takes the anchor's own colour as the target.
    assign target      = (player_q == CELL_EMPTY) ? anchor : player_q;
    assign last_anchor = (row_q == RW'(ROWS-1)) && (col_q == CW'(COLS-1));

    // Gather the cells of each direction's window; out-of-board windows are flagged invalid.
    always_comb begin
        int rr, cc, re, ce;
        rr = 0;
        cc = 0;
        re = 0;
        ce = 0;
        for (int d = 0; d < 4; d++) begin
            win_cells[d] = '0;
            re = int'(row_q) + (WIN_LEN-1) * dir_dr(d);
            ce = int'(col_q) + (WIN_LEN-1) * dir_dc(d);
            win_valid[d] = (re < ROWS) && (ce >= 0) && (ce < COLS);
            for (int k = 0; k < WIN_LEN; k++) begin
                rr = int'(row_q) + k * dir_dr(d);
                cc = int'(col_q) + k * dir_dc(d);
                if ((rr < ROWS) && (cc >= 0) && (cc < COLS)) begin
                    win_cells[d][2*k +: 2] = grid_q[2*cell_idx(rr, cc, COLS) +: 2];
                end
            end
        end
    end

    for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        win_window_check #(.WIN_LEN(WIN_LEN)) u_check (
            .cells  (win_cells[gd]),
            .valid  (win_valid[gd]),
            .target (target),
            .match  (dir_match[gd])
        );
    end

    always_comb begin
        hit     = 1'b0;
        hit_dir = DIR_RIGHT;
        for (int d = 3; d >= 0; d--) begin
            if (dir_match[d]) begin
                hit     = 1'b1;
                hit_dir = 2'(d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SCAN;
            ST_SCAN: if (hit || last_anchor) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SCAN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grid_q     <= '0;
            player_q   <= CELL_EMPTY;
            row_q      <= '0;
            col_q      <= '0;
            empty_seen <= 1'b0;
            winner     <= CELL_EMPTY;
            draw       <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_dir    <= DIR_RIGHT;
        end else if ((state == ST_IDLE) && start) begin
            grid_q     <= grid;
            player_q   <= player;
            row_q      <= '0;
            col_q      <= '0;
            empty_seen <= 1'b0;
            winner     <= CELL_EMPTY;
            draw       <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            win_dir    <= DIR_RIGHT;
        end else if (state == ST_SCAN) begin
            empty_seen <= empty_seen | (anchor == CELL_EMPTY);
            if (hit) begin
                winner  <= target;
                win_row <= row_q;
                win_col <= col_q;
                win_dir <= hit_dir;
            end else if (last_anchor) begin
                winner <= CELL_EMPTY;
                draw   <= ~(empty_seen | (anchor == CELL_EMPTY));
            end else if (col_q == CW'(COLS-1)) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule
